alu_pa_sequencer: RTL
=====================

# alu_pa_sequencer

Control sequencer for the 16-bit ALU operation stage. It accepts one ALU command at a time over a valid/ready handshake and decodes the 4-bit opcode into the one-hot PA strobe bus that drives the operation decoder. Shift and rotate commands run as repeated single-bit passes, with the result written back between passes. The block owns the architectural carry flag. It sits between instruction decode and the ALU datapath.

## Interface
Parameters:
- CNT_W, 4, width of the shift pass-count field; a command runs count+1 passes (1..16).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low, synchronous release.
- req_valid  in  1  command present.
- req_ready  out  1  sequencer can accept a command.
- req_op  in  4  opcode: 0 NOP, 1 ADD, 2 ADC, 3 SUB, 4 SBC, 5 NOT, 6 AND, 7 NLAND, 8 RLC, 9 RL, 10 SLA, 11 RRC, 12 RR, 13 SRA, 14 SRL, 15 illegal.
- req_count  in  CNT_W  shift pass count minus one; ignored for opcodes 0-7.
- alu_cout  in  1  carry-out of the current ALU pass.
- pa  out  15  one-hot PA strobes; bit i = opcode i (bit 0 PA_NOP ... bit 14 PA_SRL).
- low_load  out  1  datapath latches ALU result into the Low operand register at this edge.
- cflag  out  1  carry flag register; feeds ALU carry-in.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done for an illegal opcode.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture op into op_r and set remaining = req_count for opcodes 8-14, otherwise 0.
  - Opcode 15 goes directly to DONE with err_r=1.
  - All other opcodes go to EXEC.
- EXEC:
  - pa[op_r]=1 and low_load=1 every cycle; all other pa bits are 0.
  - At each edge:
    - If op_r is in 1-4 or 8-14, cflag<=alu_cout.
    - Otherwise cflag is unchanged.
    - If remaining==0, go to DONE; else decrement remaining and stay in EXEC.
  - NOP executes one pass with low_load=1 (Low reloads unchanged).
- DONE:
  - done=1, and err=1 if err_r.
  - pa=0, low_load=0, req_ready=0.
  - Next state IDLE; err_r cleared.
- Outside EXEC, pa=0 and low_load=0, always.
- pa is registered state decode; it is never driven combinationally from req_op.
- Exactly one pa bit is high in EXEC. No bit is high for opcode 15.
- The counter is CNT_W bits and never wraps: the decrement happens only when remaining>0.
- cflag changes only in EXEC. Requests presented while req_ready=0 are ignored and do not alter any state.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, pa=0, low_load=0, cflag=0, done=0, err=0, remaining=0, op_r=0.
- Accept at edge k (IDLE, req_valid=1):
  - EXEC occupies cycles k+1..k+N, where N=remaining+1.
  - done is high in cycle k+N+1.
  - req_ready is high again from cycle k+N+2.
- Illegal opcode accepted at edge k: done=err=1 in cycle k+1; req_ready from k+2.
- Throughput is one command per N+2 cycles. There is no overlap and no internal queue.
- The cflag update from pass j is visible to the ALU in pass j+1 (the next cycle).
- Reset asserted mid-EXEC: outputs take reset values immediately (asynchronous), and the command is dropped. No done is produced for it.
- req_valid held across DONE: the request is not accepted until the IDLE cycle.

## Test plan
- Reset, then ADD (op=1) with alu_cout=1 → pa=0x0002 for exactly 1 cycle, low_load=1 that cycle, cflag=1 after, done in cycle k+2, req_ready in cycle k+3.
- SLA (op=10, count=3) → pa=0x0400 for 4 consecutive cycles, 4 low_load pulses, cflag tracks the alu_cout of the last pass, done in cycle k+5.
- AND (op=6) with cflag=1 and alu_cout=0 → cflag stays 1; count=15 is ignored and there is a single pass.
- op=15 → no pa bit and no low_load, done=err=1 in cycle k+1, cflag unchanged.
- SRL with count=15, rst_n pulsed low during pass 7 → all outputs go to reset values immediately, no done, req_ready=1 after release.
- Back-to-back: req_valid held with ADC then SUB → second accept only in IDLE; done pulses separated by N+2 cycles; no cycle has two pa bits high.

Source files
------------

// File: rtl/alu_pa_sequencer.sv
// rtl/alu_pa_sequencer.sv - ALU command sequencer driving one-hot PA strobes and the carry flag
module alu_pa_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [CNT_W-1:0] req_count,
    input  logic             alu_cout,
    output logic [14:0]      pa,
    output logic             low_load,
    output logic             cflag,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    state_t           state;
    state_t           state_nx;
    logic [3:0]       op_r;
    logic [CNT_W-1:0] remaining;
    logic             err_r;

    // Shift/rotate opcodes (RLC..SRL) run multiple passes
    function automatic logic is_shift(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd14);
    endfunction

    // Arithmetic and shift opcodes produce a carry that the flag must follow
    function automatic logic writes_carry(input logic [3:0] op);
        return ((op >= 4'd1) && (op <= 4'd4)) || is_shift(op);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode; pa comes only from registered state and op_r
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        pa        = '0;
        low_load  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = (req_op == OP_ILLEGAL) ? DONE : EXEC;
                end
            end
            EXEC: begin
                pa       = 15'(1) << op_r;
                low_load = 1'b1;
                if (remaining == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                err      = err_r;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Command capture, pass counter, carry flag and error latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= '0;
            remaining <= '0;
            err_r     <= 1'b0;
            cflag     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_r      <= req_op;
                        remaining <= is_shift(req_op) ? req_count : '0;
                        err_r     <= (req_op == OP_ILLEGAL);
                    end
                end
                EXEC: begin
                    if (writes_carry(op_r)) begin
                        cflag <= alu_cout;
                    end
                    if (remaining != '0) begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                DONE: begin
                    err_r <= 1'b0;
                end
                default: begin
                    err_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
